// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared types and constants for the fetch program-counter sequencer.
package fetch_pc_ctrl_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned PC_STEP_DEF    = 4;
    localparam int unsigned MISS_CNT_W_DEF = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] ALIGN_MASK   = 32'hFFFF_FFFC;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MISS = 1'b1
    } fetch_state_e;

    // Redirect captured while a miss is outstanding.
    typedef struct packed {
        logic              vld;
        logic              exc;
        logic [ADDR_W-1:0] addr;
    } pend_redirect_t;

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: sequential fetch, miss/hazard hold, branch and
// exception redirects (deferred while a miss is outstanding), miss counter.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned PC_STEP    = PC_STEP_DEF,
    parameter int unsigned MISS_CNT_W = MISS_CNT_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Imiss,
    input  logic                  Hz_Stall,
    input  logic                  Br_Taken,
    input  logic [31:0]           Br_Target,
    input  logic                  Exc_Req,
    input  logic [31:0]           Exc_Vector,
    output logic [31:0]           InstrAddr,
    output logic                  IF_ID_Flush,
    output logic                  IF_ID_Stall,
    output logic [31:0]           FetchPC,
    output logic                  Fetch_Valid,
    output logic [MISS_CNT_W-1:0] Miss_Count
);

    fetch_state_e   state_q, state_d;
    pend_redirect_t pend_q, pend_d;

    logic [ADDR_W-1:0] addr_d, fpc_d, pc_inc, br_addr, exc_addr, resume_addr;
    logic              flush_d, valid_d;

    assign br_addr  = align_addr(Br_Target);
    assign exc_addr = align_addr(Exc_Vector);
    assign pc_inc   = InstrAddr + ADDR_W'(PC_STEP);

    // A pending exception outranks a branch arriving on the resolve cycle.
    always_comb begin
        resume_addr = pend_q.addr;
        if (Exc_Req) begin
            resume_addr = exc_addr;
        end else if (pend_q.vld && pend_q.exc) begin
            resume_addr = pend_q.addr;
        end else if (Br_Taken) begin
            resume_addr = br_addr;
        end
    end

    assign IF_ID_Stall = Hz_Stall | Imiss | (state_q == ST_MISS);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (!Exc_Req && !Br_Taken && Imiss) begin
                    state_d = ST_MISS;
                end
            end
            ST_MISS: begin
                if (!Imiss) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        addr_d  = InstrAddr;
        fpc_d   = FetchPC;
        flush_d = 1'b0;
        valid_d = Fetch_Valid;
        pend_d  = pend_q;
        unique case (state_q)
            ST_RUN: begin
                if (Exc_Req) begin
                    addr_d  = exc_addr;
                    flush_d = 1'b1;
                    valid_d = 1'b0;
                end else if (Br_Taken) begin
                    addr_d  = br_addr;
                    flush_d = 1'b1;
                    valid_d = 1'b0;
                end else if (Imiss) begin
                    valid_d = 1'b0;
                end else if (!Hz_Stall) begin
                    fpc_d   = InstrAddr;
                    addr_d  = pc_inc;
                    valid_d = 1'b1;
                end
            end
            ST_MISS: begin
                valid_d = 1'b0;
                if (Imiss) begin
                    if (Exc_Req) begin
                        pend_d = '{vld: 1'b1, exc: 1'b1, addr: exc_addr};
                    end else if (Br_Taken && !(pend_q.vld && pend_q.exc)) begin
                        pend_d = '{vld: 1'b1, exc: 1'b0, addr: br_addr};
                    end
                end else if (pend_q.vld || Exc_Req || Br_Taken) begin
                    addr_d  = resume_addr;
                    flush_d = 1'b1;
                    pend_d  = '0;
                end else if (!Hz_Stall) begin
                    fpc_d   = InstrAddr;
                    addr_d  = pc_inc;
                    valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            InstrAddr   <= RESET_PC;
            FetchPC     <= RESET_PC;
            IF_ID_Flush <= 1'b0;
            Fetch_Valid <= 1'b0;
            pend_q      <= '0;
        end else begin
            InstrAddr   <= addr_d;
            FetchPC     <= fpc_d;
            IF_ID_Flush <= flush_d;
            Fetch_Valid <= valid_d;
            pend_q      <= pend_d;
        end
    end

    sat_counter #(
        .W (MISS_CNT_W)
    ) u_miss_cnt (
        .clk   (Clk),
        .clr   (Rst),
        .en    (Imiss),
        .count (Miss_Count)
    );

endmodule
